// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared funct codes, FSM state encoding, accumulator type and
//               operand helper for the iterative multiply/divide sequencer.
//               The DIV state exists only when MULDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
`ifdef MULDIV_DIV_EN
    ST_DIV  = 3'd2,
`endif
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef logic [63:0] acc_t;

  // Absolute value for signed operations, raw value for unsigned ones.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               mode = 0 : shift-add multiply step. Accumulator is
//                          {partial product, remaining multiplier bits}.
//               mode = 1 : restoring shift-subtract divide step. Accumulator
//                          is {partial remainder, dividend/quotient bits}.
//               The divide path exists only with MULDIV_DIV_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step (
  input  logic        mode,
  input  logic [63:0] acc_in,
  input  logic [31:0] operand,
  output logic [63:0] acc_out
);

  logic [32:0] mul_sum;

`ifdef MULDIV_DIV_EN
  logic [32:0] rem_shift;
  logic [31:0] rem_sub;
  logic        rem_fits;

  // Multiply step: add multiplicand when the low bit is set, then shift right.
  // Divide step: shift remainder left, subtract divisor if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
    rem_shift = acc_in[63:31];
    rem_fits  = (rem_shift >= {1'b0, operand});
    // The true difference is below the divisor, so 32 bits hold it exactly.
    rem_sub   = rem_shift[31:0] - operand;
    if (mode) begin
      if (rem_fits) acc_out = {rem_sub, acc_in[30:0], 1'b1};
      else          acc_out = {rem_shift[31:0], acc_in[30:0], 1'b0};
    end else begin
      acc_out = {mul_sum, acc_in[31:1]};
    end
  end
`else
  logic unused_mode;

  // Multiply step only: add multiplicand when the low bit is set, shift right.
  always_comb begin
    unused_mode = mode;
    mul_sum     = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
    acc_out     = {mul_sum, acc_in[31:1]};
  end
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative 32-bit multiply/divide controller owning HI/LO.
//               Runs 32 iterations, a sign fix-up cycle and a done cycle,
//               holding Stall from issue until the fix-up completes.
//               MULDIV_DIV_EN enables div/divu; without it they are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Function_opcode,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  output logic        Stall,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_t      state, state_next;
  logic [4:0]  count;
  logic [63:0] acc, acc_step, prod;
  logic [31:0] operand, fix_hi, fix_lo;
  logic        neg_lo;
  logic        can_accept, is_mul_f, is_div_f, accept_op, signed_op, step_mode;
  logic [31:0] mag_rs, mag_rt;

`ifdef MULDIV_DIV_EN
  logic [31:0] rs_raw;
  logic        neg_hi, is_div_op, zero_div;
`endif

  // Issue decode: which funct is presented and whether it may be accepted.
  always_comb begin
    can_accept = (state == ST_IDLE) || (state == ST_DONE);
    is_mul_f   = start && ((Function_opcode == MULT) || (Function_opcode == MULTU));
`ifdef MULDIV_DIV_EN
    is_div_f   = start && ((Function_opcode == DIV) || (Function_opcode == DIVU));
    step_mode  = (state == ST_DIV);
`else
    is_div_f   = 1'b0;
    step_mode  = 1'b0;
`endif
    accept_op  = can_accept && (is_mul_f || is_div_f);
    signed_op  = (Function_opcode == MULT) || (Function_opcode == DIV);
    mag_rs     = magnitude(Read_data_1, signed_op);
    mag_rt     = magnitude(Read_data_2, signed_op);
  end

  muldiv_step u_step (
    .mode    (step_mode),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (acc_step)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mul_f)      state_next = ST_MUL;
`ifdef MULDIV_DIV_EN
        else if (is_div_f) state_next = ST_DIV;
`endif
      end
      ST_MUL: begin
        busy = 1'b1;
        if (count == 5'd0) state_next = ST_FIX;
      end
`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        busy = 1'b1;
        if (count == 5'd0) state_next = ST_FIX;
      end
`endif
      ST_FIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (is_mul_f)      state_next = ST_MUL;
`ifdef MULDIV_DIV_EN
        else if (is_div_f) state_next = ST_DIV;
`endif
        else               state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    Stall = busy || accept_op;
  end

`ifdef MULDIV_DIV_EN
  assign div_by_zero = done && zero_div;
`else
  assign div_by_zero = 1'b0;
`endif

  // Sign fix-up of the raw magnitude result into HI/LO values.
  always_comb begin
    prod   = neg_lo ? (~acc + 64'd1) : acc;
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div_op) begin
      if (zero_div) begin
        fix_lo = 32'hFFFF_FFFF;
        fix_hi = rs_raw;
      end else begin
        fix_lo = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
        fix_hi = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
      end
    end
`endif
  end

  // Operand latching, iteration, and HI/LO writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= 5'd0;
      acc     <= 64'd0;
      operand <= 32'd0;
      neg_lo  <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
`ifdef MULDIV_DIV_EN
      rs_raw    <= 32'd0;
      neg_hi    <= 1'b0;
      is_div_op <= 1'b0;
      zero_div  <= 1'b0;
`endif
    end else if (accept_op) begin
      count   <= 5'(ITER - 1);
      acc     <= {32'd0, is_div_f ? mag_rs : mag_rt};
      operand <= is_div_f ? mag_rt : mag_rs;
      neg_lo  <= signed_op && (Read_data_1[31] ^ Read_data_2[31]);
`ifdef MULDIV_DIV_EN
      rs_raw    <= Read_data_1;
      neg_hi    <= signed_op && Read_data_1[31];
      is_div_op <= is_div_f;
      zero_div  <= is_div_f && (Read_data_2 == 32'd0);
`endif
    end else if (can_accept && start && (Function_opcode == MTHI)) begin
      HI <= Read_data_1;
    end else if (can_accept && start && (Function_opcode == MTLO)) begin
      LO <= Read_data_1;
    end else if (state == ST_FIX) begin
      HI <= fix_hi;
      LO <= fix_lo;
    end else if (busy) begin
      acc   <= acc_step;
      count <= count - 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. A timeline model
//               predicts Stall/busy/done/div_by_zero/HI/LO every cycle from
//               plain arithmetic; directed vectors carry literal expectations.
//               Div expectations follow MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic        Stall, busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  muldiv_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .Function_opcode (funct),
    .Read_data_1     (rd1),
    .Read_data_2     (rd2),
    .Stall           (Stall),
    .busy            (busy),
    .done            (done),
    .div_by_zero     (div_by_zero),
    .HI              (HI),
    .LO              (LO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_md(input logic [5:0] f);
    return (f == MULT) || (f == MULTU) || (DIV_EN && ((f == DIV) || (f == DIVU)));
  endfunction

  task automatic calc(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint p;
    int sa, sb;
    dz = 1'b0;
    hi = 32'd0;
    lo = 32'd0;
    sa = a;
    sb = b;
    if (f == MULT) begin
      p = longint'(sa) * longint'(sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (f == MULTU) begin
      p = longint'({32'd0, a}) * longint'({32'd0, b});
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      dz = 1'b1;
    end else if (f == DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else begin
        lo = sa / sb;
        hi = sa % sb;
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  // phase: 0 idle, 1..32 iterating, 33 fix-up, 34 done
  int          phase = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_dz = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      phase = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
    end else if (phase >= 1 && phase <= 32) begin
      phase++;
    end else if (phase == 33) begin
      m_hi  = p_hi;
      m_lo  = p_lo;
      phase = 34;
    end else begin
      phase = 0;
      if (start && is_md(funct)) begin
        calc(funct, rd1, rd2, p_hi, p_lo, p_dz);
        phase = 1;
      end else if (start && funct == MTHI) begin
        m_hi = rd1;
      end else if (start && funct == MTLO) begin
        m_lo = rd1;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("stall", Stall, (phase >= 1 && phase <= 33) ||
            (start && is_md(funct) && (phase == 0 || phase == 34)));
      check("busy",  busy, phase >= 1 && phase <= 33);
      check("done",  done, phase == 34);
      check("dz",    div_by_zero, phase == 34 && p_dz);
      check("HI",    HI, m_hi);
      check("LO",    LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int sc, output int dc, output bit dzs);
    @(posedge clock); #1;
    start = 1'b1; funct = f; rd1 = a; rd2 = b;
    sc = 0; dc = -1; dzs = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (Stall) sc++;
      if (done && dc < 0) begin dc = c; dzs = div_by_zero; end
      @(posedge clock); #1;
      start = 1'b0;
      if (dc >= 0) break;
    end
  endtask

  initial begin
    int sc, dc, cnt;
    bit dzs, seen;
    logic [31:0] hi0, lo0;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checking = 1'b1;
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_stall", Stall, 1'b0);
    check("rst_busy", busy, 1'b0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, dc, dzs);
    check("multu_HI", HI, 32'hFFFF_FFFE);
    check("multu_LO", LO, 32'h0000_0001);
    check("multu_stall_cycles", sc, 34);
    check("multu_done_cycle", dc, 34);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, sc, dc, dzs);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFEB);

    hi0 = HI; lo0 = LO;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, sc, dc, dzs);
`ifdef MULDIV_DIV_EN
    check("div_LO", LO, 32'hFFFF_FFFD);
    check("div_HI", HI, 32'hFFFF_FFFF);
    check("div_done_cycle", dc, 34);
    run_op(DIVU, 32'h8000_0000, 32'd3, sc, dc, dzs);
    check("divu_LO", LO, 32'h2AAA_AAAA);
    check("divu_HI", HI, 32'd2);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, dc, dzs);
    check("div_ovf_LO", LO, 32'h8000_0000);
    check("div_ovf_HI", HI, 32'd0);
    run_op(DIVU, 32'd5, 32'd0, sc, dc, dzs);
    check("divz_LO", LO, 32'hFFFF_FFFF);
    check("divz_HI", HI, 32'd5);
    check("divz_flag", dzs, 1'b1);
    check("divz_done_cycle", dc, 34);
`else
    check("div_off_stall", sc, 0);
    check("div_off_HI", HI, hi0);
    check("div_off_LO", LO, lo0);
    run_op(DIVU, 32'd5, 32'd0, sc, dc, dzs);
    check("divz_off_stall", sc, 0);
    check("divz_off_HI", HI, hi0);
    check("divz_off_LO", LO, lo0);
    check("divz_off_flag", dzs, 1'b0);
`endif

    // mthi then mtlo on consecutive cycles, plus an unknown funct afterwards
    @(posedge clock); #1;
    start = 1'b1; funct = MTHI; rd1 = 32'h1234; seen = 1'b0;
    @(negedge clock); seen |= Stall;
    @(posedge clock); #1;
    funct = MTLO; rd1 = 32'h5678;
    @(negedge clock); seen |= Stall;
    @(posedge clock); #1;
    funct = 6'b100000; rd1 = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0;
    check("mthi_HI", HI, 32'h1234);
    check("mtlo_LO", LO, 32'h5678);
    check("mtx_stall", seen, 1'b0);

    // a second mult start in cycle 5 of a busy op is ignored
    @(posedge clock); #1;
    start = 1'b1; funct = MULT; rd1 = 32'd6; rd2 = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1 start = 1'b1; rd1 = 32'd100; rd2 = 32'd100;
    @(posedge clock); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      seen = done;
    end
    check("ign_done_seen", seen, 1'b1);
    @(posedge clock); #1;
    check("ign_HI", HI, 32'd0);
    check("ign_LO", LO, 32'd42);

    // reset in cycle 10 of a mult discards the result
    @(posedge clock); #1;
    start = 1'b1; funct = MULT; rd1 = 32'h1000; rd2 = 32'h1000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_stall", Stall, 1'b0);
    check("rstmid_HI", HI, 32'd0);
    check("rstmid_LO", LO, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) cnt++;
    end
    check("rstmid_no_done", cnt, 0);

    @(posedge clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
